spi_sram_bus_bridge: RTL and testbench
======================================

# spi_sram_bus_bridge

Memory responder for the `cpu_6502` bus. Accepts the CPU's per-cycle memory requests (`ab`, `dout`, `we`, `men`, `iread`) and serves them from an external 64 KiB SPI SRAM (23LC512-style command set, sequential mode). It stalls the CPU through `rdy` for the duration of each SPI transfer. Consecutive instruction fetches are streamed without re-issuing a command. This block replaces the behavioural `mem` array of the simulation benches in silicon builds.

## Interface
- `SEQ_EN`, default 1: enables streaming of sequential instruction fetches (CS held low between reads).
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ab` in 16: CPU address.
- `dout` in 8: CPU write data.
- `we` in 1: CPU write strobe; qualified by `men`.
- `men` in 1: CPU memory access enable.
- `iread` in 1: access is an opcode/operand fetch at PC.
- `din` out 8: read data to CPU (registered).
- `rdy` out 1: CPU advance enable (combinational from state and `men`).
- `spi_sck` out 1: SPI clock, mode 0, clk/2.
- `spi_cs_n` out 1: SPI chip select, active low.
- `spi_mosi` out 1: SPI data out, MSB first.
- `spi_miso` in 1: SPI data in.

## Operation
- States: IDLE (CS high), SHIFT (bits clocking), DONE (one cycle, access complete), HOLD (CS low, SCK low, read stream open), CSHI (one cycle, CS forced high).
- `rdy` = 1 in IDLE/HOLD when `men`=0, and in DONE. `rdy` = 0 in all other cases: IDLE/HOLD with `men`=1, SHIFT, CSHI.
- IDLE, `men`=1: latch `ab`, `we`, `dout`. Load a 32-bit shift register: read = {0x03, ab, 0x00}, write = {0x02, ab, dout}. Set `spi_cs_n`=0. Go to SHIFT with count 64.
- SHIFT: `spi_sck` = count bit 0 phase. Low half first, 32 SCK periods per full transfer. `spi_mosi` = shift-register MSB, updated only while SCK is low. `spi_miso` is sampled into a data register at the clk edge that ends each SCK-high cycle. At count exhaustion go to DONE.
- DONE, read: `din` was loaded with the 8 sampled bits on entry to DONE. Store next_addr = latched ab + 1 (16-bit, wraps 0xFFFF→0x0000). Go to HOLD if `SEQ_EN`, else raise CS and go to IDLE.
- DONE, write: `din` is unchanged. Raise CS and go to IDLE.
- A `men` that is high during the DONE cycle belongs to the access being completed. It is never a new request.
- HOLD, `men`=1, `we`=0, `iread`=1, `ab`==next_addr: data-only SHIFT of 16 clk (8 SCK). No command or address is sent.
- HOLD, any other `men`=1 request: go to CSHI (`spi_cs_n`=1 for one cycle), then start as from IDLE with the request that is still held.
- HOLD, `men`=0: stay in HOLD; CS stays low indefinitely.
- A write always terminates an open stream: HOLD → CSHI → write.
- `spi_sck` is 0 in every state except SHIFT high-phase cycles.

## Timing
- Reset values: state IDLE, `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0, `din`=0x00, next_addr invalid. `rdy` = !`men`.
- Reset mid-transfer: the next cycle is IDLE with CS high. The partial SPI transfer is abandoned, and a partial write is not committed by a compliant SRAM.
- Full access from IDLE: 1 request cycle + 64 SHIFT cycles with `rdy`=0. DONE follows with `rdy`=1, i.e. the 66th cycle of the access.
- Streamed fetch from HOLD: 1 request cycle + 16 SHIFT cycles with `rdy`=0, then DONE.
- Broken stream: one additional CSHI cycle, giving 66 `rdy`=0 cycles.
- `din` is valid from the cycle after DONE and holds until the next read's DONE. This matches the bench memory's one-cycle registered read.
- `spi_cs_n` fall to first SCK rise: ≥1 clk. Last SCK fall to CS rise: ≥1 clk. CS high time: ≥1 clk.

## Test plan
- Reset with `men`=0 → `spi_cs_n`=1, `spi_sck`=0, `din`=0x00, `rdy`=1. Assert `rst` mid-SHIFT → CS high on the next cycle, state IDLE.
- Read `ab`=0x1234, SRAM model byte 0xA5 → MOSI stream 03 12 34. `rdy`=0 for exactly 65 cycles. `din`=0xA5 the cycle after DONE. CS stays low (HOLD).
- Write `ab`=0x0200, `dout`=0x5A → MOSI 02 02 00 5A, 32 SCK. CS high after DONE, model[0x0200]=0x5A, `din` unchanged.
- Fetches at 0x0400 then 0x0401 with `iread`=1 → second fetch sends no command, 8 SCK, `rdy`=0 for 17 cycles, returns model[0x0401].
- Stream open at next_addr 0x0401, then `iread`=0 read of 0x00F0 → 1 CSHI cycle, full command 03 00 F0, 66 `rdy`-low cycles.
- Fetch at 0xFFFF then `iread` at 0x0000 → treated as sequential (streamed, 17 cycles), returns model[0x0000]. With `SEQ_EN`=0 → every access takes 65 cycles and CS rises after each access.

Source files
------------

// File: rtl/spi_sram_bus_bridge.sv
// spi_sram_bus_bridge: serves cpu_6502 bus cycles from a 23LC512-style SPI SRAM,
// stalling through rdy and streaming sequential opcode fetches over an open read.
module spi_sram_bus_bridge #(
    parameter bit SEQ_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ab,
    input  logic [7:0]  dout,
    input  logic        we,
    input  logic        men,
    input  logic        iread,
    output logic [7:0]  din,
    output logic        rdy,
    output logic        spi_sck,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    typedef enum logic [2:0] {IDLE, SHIFT, DONE, HOLD, CSHI} state_t;
    state_t      st_q;
    logic [6:0]  cnt_q;
    logic [31:0] sr_q;
    logic [15:0] a_q, na_q;
    logic        we_q, cs_n_q;
    logic [7:0]  din_q;
    logic        seq;
    logic [31:0] cmd;
    assign seq      = men && !we && iread && ab == na_q;
    assign cmd      = we ? {8'h02, ab, dout} : {8'h03, ab, 8'h00};
    assign rdy      = st_q == DONE || ((st_q == IDLE || st_q == HOLD) && !men);
    assign spi_sck  = st_q == SHIFT && cnt_q[0];
    assign spi_cs_n = cs_n_q;
    assign spi_mosi = sr_q[31];
    assign din      = din_q;
    // The shift register doubles as the receive register: MISO enters at the LSB
    // on the edge that ends each SCK-high cycle, while MOSI only moves during SCK low.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= IDLE;
            cnt_q  <= '0;
            sr_q   <= '0;
            a_q    <= '0;
            na_q   <= '0;
            we_q   <= 1'b0;
            cs_n_q <= 1'b1;
            din_q  <= '0;
        end else begin
            case (st_q)
                IDLE, CSHI: begin
                    if (men) begin
                        a_q    <= ab;
                        we_q   <= we;
                        sr_q   <= cmd;
                        cs_n_q <= 1'b0;
                        cnt_q  <= 7'd64;
                        st_q   <= SHIFT;
                    end else begin
                        st_q   <= IDLE;
                    end
                end
                SHIFT: begin
                    cnt_q <= cnt_q - 7'd1;
                    if (cnt_q[0]) sr_q <= {sr_q[30:0], spi_miso};
                    if (cnt_q == 7'd1) begin
                        st_q <= DONE;
                        if (!we_q) din_q <= {sr_q[6:0], spi_miso};
                    end
                end
                DONE: begin
                    if (!we_q) na_q <= a_q + 16'd1;
                    if (we_q || !SEQ_EN) begin
                        cs_n_q <= 1'b1;
                        st_q   <= IDLE;
                    end else begin
                        st_q   <= HOLD;
                    end
                end
                HOLD: begin
                    if (men && seq) begin
                        a_q   <= ab;
                        we_q  <= 1'b0;
                        sr_q  <= '0;
                        cnt_q <= 7'd16;
                        st_q  <= SHIFT;
                    end else if (men) begin
                        cs_n_q <= 1'b1;
                        st_q   <= CSHI;
                    end
                end
                default: st_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_sram_bus_bridge.sv
// tb_spi_sram_bus_bridge: directed checks of the SPI SRAM bridge against a behavioural SRAM.
module tb_spi_sram_bus_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ab = '0, ab2 = '0;
    logic [7:0]  dout = '0;
    logic        we = 1'b0, men = 1'b0, iread = 1'b0;
    logic        men2 = 1'b0, iread2 = 1'b0;
    logic [7:0]  din, din2;
    logic        rdy, rdy2, spi_sck, spi_cs_n, spi_mosi, sck2, cs2_n, mosi2;
    logic        miso = 1'b0;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    spi_sram_bus_bridge dut (
        .clk(clk), .rst(rst), .ab(ab), .dout(dout), .we(we), .men(men), .iread(iread),
        .din(din), .rdy(rdy), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(miso)
    );

    spi_sram_bus_bridge #(.SEQ_EN(1'b0)) dut2 (
        .clk(clk), .rst(rst), .ab(ab2), .dout(8'h00), .we(1'b0), .men(men2), .iread(iread2),
        .din(din2), .rdy(rdy2), .spi_sck(sck2), .spi_cs_n(cs2_n), .spi_mosi(mosi2),
        .spi_miso(1'b0)
    );

    logic [7:0]  mem [0:65535];
    int          bitc = 0, sck_rises = 0;
    logic [7:0]  mcmd = '0, wbyte = '0, obyte = '0;
    logic [15:0] maddr = '0, cap_addr = '0;

    // Mode-0 SRAM: samples MOSI on SCK rise, drives MISO after SCK fall, sequential addressing.
    always @(spi_sck or spi_cs_n) begin
        if (spi_cs_n) begin
            bitc = 0;
            miso = 1'b0;
        end else if (spi_sck) begin
            sck_rises++;
            if (bitc < 8) mcmd = {mcmd[6:0], spi_mosi};
            else if (bitc < 24) maddr = {maddr[14:0], spi_mosi};
            else if (mcmd == 8'h02) begin
                wbyte = {wbyte[6:0], spi_mosi};
                if (bitc % 8 == 7) begin
                    mem[maddr] = wbyte;
                    maddr++;
                end
            end
            bitc++;
            if (bitc == 24) cap_addr = maddr;
        end else if (mcmd == 8'h03 && bitc >= 24) begin
            if (bitc % 8 == 0) begin
                obyte = mem[maddr];
                maddr++;
            end
            miso = obyte[7 - (bitc % 8)];
        end
    end

    task automatic access(input bit sel, input logic [15:0] a, input logic w, input logic [7:0] d,
                          input logic ir, output int lows, output int rises);
        int s0;
        @(negedge clk);
        if (sel) begin
            ab2 = a; iread2 = ir; men2 = 1'b1;
        end else begin
            ab = a; we = w; dout = d; iread = ir; men = 1'b1;
        end
        s0 = sck_rises;
        lows = 0;
        #1;
        while (!(sel ? rdy2 : rdy) && lows < 200) begin
            lows++;
            @(negedge clk);
        end
        rises = sck_rises - s0;
        @(posedge clk);
        #1;
        men = 1'b0; we = 1'b0; iread = 1'b0; men2 = 1'b0; iread2 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        men = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy_men1 got %b exp 0", rdy); end
        men = 1'b0;
        #1;
        checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs got %b exp 1", spi_cs_n); end
        checks++; if (spi_sck !== 1'b0) begin errors++; $display("FAIL reset_sck got %b exp 0", spi_sck); end
        checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b exp 0", spi_mosi); end
        checks++; if (din !== 8'h00) begin errors++; $display("FAIL reset_din got %h exp 00", din); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b exp 1", rdy); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read;
        int lows, rises;
        access(1'b0, 16'h1234, 1'b0, 8'h00, 1'b0, lows, rises);
        checks++; if (lows !== 65) begin errors++; $display("FAIL read_lows got %0d exp 65", lows); end
        checks++; if (rises !== 32) begin errors++; $display("FAIL read_sck got %0d exp 32", rises); end
        checks++; if (mcmd !== 8'h03) begin errors++; $display("FAIL read_cmd got %h exp 03", mcmd); end
        checks++; if (cap_addr !== 16'h1234) begin errors++; $display("FAIL read_addr got %h exp 1234", cap_addr); end
        checks++; if (din !== 8'hA5) begin errors++; $display("FAIL read_din got %h exp a5", din); end
        checks++; if (spi_cs_n !== 1'b0) begin errors++; $display("FAIL read_hold_cs got %b exp 0", spi_cs_n); end
        checks++; if (spi_sck !== 1'b0) begin errors++; $display("FAIL read_hold_sck got %b exp 0", spi_sck); end
    endtask

    task automatic test_write;
        int lows, rises;
        access(1'b0, 16'h0200, 1'b1, 8'h5A, 1'b0, lows, rises);
        checks++; if (lows !== 66) begin errors++; $display("FAIL write_lows got %0d exp 66", lows); end
        checks++; if (rises !== 32) begin errors++; $display("FAIL write_sck got %0d exp 32", rises); end
        checks++; if (mcmd !== 8'h02) begin errors++; $display("FAIL write_cmd got %h exp 02", mcmd); end
        checks++; if (cap_addr !== 16'h0200) begin errors++; $display("FAIL write_addr got %h exp 0200", cap_addr); end
        checks++; if (mem[16'h0200] !== 8'h5A) begin errors++; $display("FAIL write_mem got %h exp 5a", mem[16'h0200]); end
        checks++; if (din !== 8'hA5) begin errors++; $display("FAIL write_din got %h exp a5", din); end
        checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL write_cs got %b exp 1", spi_cs_n); end
    endtask

    task automatic test_stream;
        int lows, rises;
        access(1'b0, 16'h0400, 1'b0, 8'h00, 1'b1, lows, rises);
        checks++; if (lows !== 65) begin errors++; $display("FAIL fetch1_lows got %0d exp 65", lows); end
        checks++; if (din !== 8'h11) begin errors++; $display("FAIL fetch1_din got %h exp 11", din); end
        access(1'b0, 16'h0401, 1'b0, 8'h00, 1'b1, lows, rises);
        checks++; if (lows !== 17) begin errors++; $display("FAIL fetch2_lows got %0d exp 17", lows); end
        checks++; if (rises !== 8) begin errors++; $display("FAIL fetch2_sck got %0d exp 8", rises); end
        checks++; if (din !== 8'h22) begin errors++; $display("FAIL fetch2_din got %h exp 22", din); end
    endtask

    task automatic test_break;
        int lows, rises;
        access(1'b0, 16'h00F0, 1'b0, 8'h00, 1'b0, lows, rises);
        checks++; if (lows !== 66) begin errors++; $display("FAIL break_lows got %0d exp 66", lows); end
        checks++; if (cap_addr !== 16'h00F0) begin errors++; $display("FAIL break_addr got %h exp 00f0", cap_addr); end
        checks++; if (rises !== 32) begin errors++; $display("FAIL break_sck got %0d exp 32", rises); end
        checks++; if (din !== 8'h33) begin errors++; $display("FAIL break_din got %h exp 33", din); end
    endtask

    task automatic test_wrap;
        int lows, rises;
        access(1'b0, 16'hFFFF, 1'b0, 8'h00, 1'b1, lows, rises);
        checks++; if (lows !== 66) begin errors++; $display("FAIL wrap1_lows got %0d exp 66", lows); end
        checks++; if (din !== 8'h44) begin errors++; $display("FAIL wrap1_din got %h exp 44", din); end
        access(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, lows, rises);
        checks++; if (lows !== 17) begin errors++; $display("FAIL wrap2_lows got %0d exp 17", lows); end
        checks++; if (din !== 8'h55) begin errors++; $display("FAIL wrap2_din got %h exp 55", din); end
    endtask

    task automatic test_seq_off;
        int lows, rises;
        access(1'b1, 16'h0400, 1'b0, 8'h00, 1'b1, lows, rises);
        checks++; if (lows !== 65) begin errors++; $display("FAIL noseq1_lows got %0d exp 65", lows); end
        checks++; if (cs2_n !== 1'b1) begin errors++; $display("FAIL noseq1_cs got %b exp 1", cs2_n); end
        access(1'b1, 16'h0401, 1'b0, 8'h00, 1'b1, lows, rises);
        checks++; if (lows !== 65) begin errors++; $display("FAIL noseq2_lows got %0d exp 65", lows); end
        checks++; if (cs2_n !== 1'b1) begin errors++; $display("FAIL noseq2_cs got %b exp 1", cs2_n); end
    endtask

    task automatic test_reset_mid;
        int lows, rises;
        @(negedge clk);
        ab = 16'h0400; iread = 1'b0; we = 1'b0; men = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (spi_cs_n !== 1'b0) begin errors++; $display("FAIL mid_cs_before got %b exp 0", spi_cs_n); end
        rst = 1'b1;
        men = 1'b0;
        @(negedge clk);
        checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL mid_cs got %b exp 1", spi_cs_n); end
        checks++; if (spi_sck !== 1'b0) begin errors++; $display("FAIL mid_sck got %b exp 0", spi_sck); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL mid_rdy got %b exp 1", rdy); end
        rst = 1'b0;
        access(1'b0, 16'h0401, 1'b0, 8'h00, 1'b0, lows, rises);
        checks++; if (lows !== 65) begin errors++; $display("FAIL mid_after_lows got %0d exp 65", lows); end
        checks++; if (din !== 8'h22) begin errors++; $display("FAIL mid_after_din got %h exp 22", din); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h1234] = 8'hA5;
        mem[16'h0400] = 8'h11;
        mem[16'h0401] = 8'h22;
        mem[16'h00F0] = 8'h33;
        mem[16'hFFFF] = 8'h44;
        mem[16'h0000] = 8'h55;
        test_reset;
        test_read;
        test_write;
        test_stream;
        test_break;
        test_wrap;
        test_seq_off;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
